// File: rtl/vxu_addsub_half_pkg.sv
// Shared VXU types for the modular add/subtract/halve stage.
// The word width is fixed here; the stage's data_width_p must match it.
package vxu_addsub_half_pkg;

    localparam int unsigned VXU_DATA_W = 64;

    typedef logic [VXU_DATA_W-1:0] vxu_word_t;

    // Stage-1 beat: reduced sum/difference plus the per-beat modulus and mode.
    typedef struct packed {
        vxu_word_t s;
        vxu_word_t d;
        vxu_word_t q;
        logic      halve;
    } vxu_addsub_beat_t;

    // (q+1)/2 for odd q, written so it cannot overflow when q is near 2^W.
    function automatic vxu_word_t vxu_half_of_q_plus_one(input vxu_word_t q);
        return (q >> 1) + vxu_word_t'(1);
    endfunction

endpackage

// File: rtl/vxu_addsub_half_halfred.sv
// halfred: combinational x * 1/2 mod q for odd q and 0 <= x < q.
// Even x halves exactly; odd x adds (q+1)/2, i.e. (x+q)/2 without a carry.
module halfred
    import vxu_addsub_half_pkg::*;
#(
    parameter int unsigned width_p = VXU_DATA_W
) (
    input  logic [width_p-1:0] x_i,
    input  logic [width_p-1:0] q_i,
    output logic [width_p-1:0] y_o
);

    logic [width_p-1:0] q_half_up;
    logic [width_p-1:0] addend;

    always_comb begin
        q_half_up = (q_i >> 1) + {{(width_p-1){1'b0}}, 1'b1};
        addend    = x_i[0] ? q_half_up : '0;
        y_o       = (x_i >> 1) + addend;
    end

endmodule

// File: rtl/vxu_addsub_half.sv
// Two-stage modular add/subtract with optional multiply by 1/2 mod q.
// Stage 1 reduces a+b and a-b into [0, q); stage 2 optionally halves both.
module vxu_addsub_half
    import vxu_addsub_half_pkg::*;
#(
    parameter int unsigned data_width_p = VXU_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [data_width_p-1:0] a_i,
    input  logic [data_width_p-1:0] b_i,
    input  logic [data_width_p-1:0] mod_i,
    input  logic                    halve_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [data_width_p-1:0] sum_o,
    output logic [data_width_p-1:0] diff_o
);

    localparam int unsigned W = data_width_p;

    // Handshake: a beat moves across a boundary exactly on a cycle where the
    // sender's valid and the receiver's ready are both high; a stage is ready
    // when it is empty or its own contents leave in the same cycle.
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic r2;
    logic in_fire;
    logic adv;
    logic out_fire;

    vxu_addsub_beat_t st1_q, st1_d;
    vxu_word_t        sum_q, sum_d;
    vxu_word_t        diff_q, diff_d;

    logic [W:0]   sum_wide;
    logic [W:0]   mod_wide;
    logic [W:0]   sum_red;
    logic [W-1:0] diff_red;

    vxu_word_t half_s;
    vxu_word_t half_d;

    always_comb begin
        r2       = !v2_q || ready_i;
        ready_o  = !v1_q || r2;
        in_fire  = valid_i && ready_o;
        adv      = v1_q && r2;
        out_fire = v2_q && ready_i;
        valid_o  = v2_q;
        sum_o    = sum_q;
        diff_o   = diff_q;
    end

    // Stage 1: the sum needs W+1 bits because a+b can reach 2q-2.
    always_comb begin
        mod_wide = {1'b0, mod_i};
        sum_wide = {1'b0, a_i} + {1'b0, b_i};
        sum_red  = (sum_wide >= mod_wide) ? (sum_wide - mod_wide) : sum_wide;
        if (a_i >= b_i) begin
            diff_red = a_i - b_i;
        end else begin
            diff_red = a_i - b_i + mod_i;
        end
    end

    always_comb begin
        v1_d  = v1_q;
        st1_d = st1_q;
        if (in_fire) begin
            v1_d        = 1'b1;
            st1_d.s     = sum_red[W-1:0];
            st1_d.d     = diff_red;
            st1_d.q     = mod_i;
            st1_d.halve = halve_i;
        end else if (adv) begin
            v1_d = 1'b0;
        end
    end

    halfred #(
        .width_p (W)
    ) u_half_s (
        .x_i (st1_q.s),
        .q_i (st1_q.q),
        .y_o (half_s)
    );

    halfred #(
        .width_p (W)
    ) u_half_d (
        .x_i (st1_q.d),
        .q_i (st1_q.q),
        .y_o (half_d)
    );

    always_comb begin
        v2_d   = v2_q;
        sum_d  = sum_q;
        diff_d = diff_q;
        if (adv) begin
            v2_d   = 1'b1;
            sum_d  = st1_q.halve ? half_s : st1_q.s;
            diff_d = st1_q.halve ? half_d : st1_q.d;
        end else if (out_fire) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            st1_q  <= '0;
            sum_q  <= '0;
            diff_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            st1_q  <= st1_d;
            sum_q  <= sum_d;
            diff_q <= diff_d;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only operand check; hardware does no range checking.
    always @(posedge clk_i) begin
        if (!rst_i && in_fire) begin
            assert (mod_i[0] && !mod_i[W-1] && (mod_i >= 3) && (a_i < mod_i) && (b_i < mod_i))
            else $error("vxu_addsub_half: operand out of range (a=%h b=%h q=%h)", a_i, b_i, mod_i);
        end
    end
`endif

endmodule

// File: tb/tb_vxu_addsub_half.sv
// Self-checking bench for vxu_addsub_half: directed vector table, hand-written
// stall/reset sequences and a long randomized run against a modular-arithmetic model.
module tb_vxu_addsub_half;

  localparam int W = 64;
  typedef logic [W-1:0] word_t;

  typedef struct {
    word_t a;
    word_t b;
    word_t q;
    logic  h;
    word_t es;
    word_t ed;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_i = 1'b1;
  logic  valid_i = 1'b0;
  logic  ready_o;
  word_t a_i = '0;
  word_t b_i = '0;
  word_t mod_i = 64'd3;
  logic  halve_i = 1'b0;
  logic  valid_o;
  logic  ready_i = 1'b1;
  word_t sum_o;
  word_t diff_o;

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [2*W-1:0] exp_q[$];

  vxu_addsub_half #(.data_width_p(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .mod_i   (mod_i),
    .halve_i (halve_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .diff_o  (diff_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic, halving as multiplication by the inverse of 2.
  function automatic logic [2*W-1:0] model(input word_t a, input word_t b, input word_t q, input logic h);
    logic [127:0] s, d, qq, inv;
    qq = {64'b0, q};
    s  = ({64'b0, a} + {64'b0, b}) % qq;
    d  = ({64'b0, a} + qq - {64'b0, b}) % qq;
    if (h) begin
      inv = (qq + 128'd1) >> 1;
      s   = (s * inv) % qq;
      d   = (d * inv) % qq;
    end
    return {s[63:0], d[63:0]};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat actual=%h_%h expected=none t=%0t", sum_o, diff_o, $time);
      end else begin
        check("result_beat", {sum_o, diff_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input word_t a, input word_t b, input word_t q, input logic h,
                      input word_t es, input word_t ed);
    int n;
    n = 0;
    a_i = a; b_i = b; mod_i = q; halve_i = h; valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout actual=ready_o_low expected=accept t=%0t", $time);
    end else begin
      exp_q.push_back({es, ed});
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_model(input word_t a, input word_t b, input word_t q, input logic h);
    logic [2*W-1:0] r;
    r = model(a, b, q, h);
    send(a, b, q, h, r[2*W-1:W], r[W-1:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic word_t rand_q();
    word_t r;
    word_t q;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: q = word_t'($urandom_range(1, 500) * 2 + 1);
      1: q = {32'b0, r[31:0]} | 64'd1;
      2: q = 64'h7FFF_FFFF_FFFF_FFFF;
      default: q = {1'b0, r[62:0]} | 64'd1;
    endcase
    if (q < 3) q = 64'd3;
    return q;
  endfunction

  vec_t tbl[$];
  word_t qw, qm, snap;
  int out_before;
  logic bp_done;
  logic rnd_done;

  // ---------------- test ----------------
  initial begin
    qw = 64'h7FFF_FFFF_FFFF_FFE7;  // 2^63 - 25
    qm = 64'h7FFF_FFFF_FFFF_FFFF;  // largest odd q
    tbl.push_back('{a:5,  b:3,  q:17, h:1, es:4,  ed:1});
    tbl.push_back('{a:3,  b:5,  q:17, h:1, es:4,  ed:16});
    tbl.push_back('{a:16, b:16, q:17, h:1, es:16, ed:0});
    tbl.push_back('{a:10, b:9,  q:17, h:0, es:2,  ed:1});
    tbl.push_back('{a:50, b:60, q:97, h:1, es:55, ed:92});
    tbl.push_back('{a:96, b:1,  q:97, h:0, es:0,  ed:95});
    tbl.push_back('{a:10, b:9,  q:17, h:0, es:2,  ed:1});
    tbl.push_back('{a:2,  b:2,  q:3,  h:1, es:2,  ed:0});
    tbl.push_back('{a:qw-1, b:qw-1, q:qw, h:1, es:qw-1, ed:0});
    tbl.push_back('{a:qw-1, b:qw-2, q:qw, h:0, es:qw-3, ed:1});
    tbl.push_back('{a:0,    b:qw-1, q:qw, h:0, es:qw-1, ed:1});
    tbl.push_back('{a:qm-1, b:0,    q:qm, h:1, es:64'h3FFF_FFFF_FFFF_FFFF, ed:64'h3FFF_FFFF_FFFF_FFFF});

    // reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_valid_o", valid_o, 0);
    check("reset_ready_o", ready_o, 1);
    check("reset_sum_o", sum_o, 0);
    check("reset_diff_o", diff_o, 0);
    @(posedge clk); #1;

    // first beat: latency
    send(tbl[0].a, tbl[0].b, tbl[0].q, tbl[0].h, tbl[0].es, tbl[0].ed);
    @(negedge clk);
    check("latency_cycle1_valid", valid_o, 0);
    @(negedge clk);
    check("latency_cycle2_valid", valid_o, 1);
    @(posedge clk); #1;

    // remaining table entries back-to-back with mixed q and halve
    for (int i = 1; i < tbl.size(); i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].h, tbl[i].es, tbl[i].ed);
    end
    wait_drain();

    // back-pressure: 6 beats, output stalled
    @(posedge clk); #1;
    ready_i = 1'b0;
    bp_done = 1'b0;
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_model(word_t'(i * 3), word_t'(16 - i * 2), 64'd17, logic'(i % 2));
        end
        bp_done = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    check("bp_accepted_two", exp_q.size(), 2);
    check("bp_ready_low", ready_o, 0);
    snap = sum_o;
    repeat (4) begin
      @(negedge clk);
      check("bp_sum_stable", sum_o, snap);
      check("bp_still_two", exp_q.size(), 2);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    #1;
    check("bp_ready_same_cycle", ready_o, 1);
    for (int n = 0; n < 200 && !bp_done; n++) @(negedge clk);
    check("bp_sender_done", bp_done, 1);
    wait_drain();
    check("bp_six_out", n_out - out_before, 6);

    // reset with two beats in flight
    @(posedge clk); #1;
    ready_i = 1'b0;
    send_model(64'd1, 64'd2, 64'd17, 1'b1);
    send_model(64'd7, 64'd4, 64'd17, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete();
    out_before = n_out;
    @(negedge clk);
    check("rst_mid_valid_o", valid_o, 0);
    check("rst_mid_sum_o", sum_o, 0);
    check("rst_mid_diff_o", diff_o, 0);
    check("rst_mid_ready_o", ready_o, 1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_stale", n_out - out_before, 0);

    // randomized traffic against the model
    @(posedge clk); #1;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          word_t q;
          word_t ra, rb;
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          q  = rand_q();
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          send_model(ra % q, rb % q, q, logic'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    wait_drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vxu_addsub_half.md
# vxu_addsub_half

Pipelined modular add/subtract stage of the VXU: for each operand pair (a, b) under odd modulus q it produces (a+b) mod q and (a−b) mod q, optionally multiplied by 1/2 mod q. It sits directly upstream of the per-lane inverse-NTT/scaling path. It absorbs the combinational 1/2-mod-q reduction (`halfred`) into a registered, back-pressurable two-stage pipeline with valid/ready on both sides.

## Interface
- `data_width_p`, default 64: operand, modulus and result width W.
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `valid_i` input 1: upstream beat valid.
- `ready_o` output 1: block accepts a beat this cycle.
- `a_i` input W: operand a, must satisfy 0 ≤ a < q.
- `b_i` input W: operand b, must satisfy 0 ≤ b < q.
- `mod_i` input W: modulus q, sampled per beat; must be odd, 3 ≤ q ≤ 2^(W−1).
- `halve_i` input 1: 1 → outputs multiplied by 1/2 mod q; 0 → plain results.
- `valid_o` output 1: result beat valid.
- `ready_i` input 1: downstream accepts.
- `sum_o` output W: (a+b)·h mod q, where h = 1/2 if halve, else 1.
- `diff_o` output W: (a−b)·h mod q.

## Operation
- Transfer occurs on a cycle where valid and ready are both high, on each side independently.
- **Stage 1**, registered on input transfer:
  - s = a+b computed in W+1 bits; if s ≥ q then s−q.
  - d = a−b if a ≥ b, else a−b+q.
  - Stores s and d as W-bit values, plus q and halve.
- **Stage 2**, registered on stage-1 → stage-2 advance:
  - If halve: each of s, d → (x>>1) + (x[0] ? (q+1)>>1 : 0).
  - Else: passes s, d unchanged.
  - All results lie in [0, q).
- Per-beat q and halve travel with the data; back-to-back beats with different q are legal.
- Stage valid flags: v1, v2.
  - Stage 2 ready: r2 = !v2 || ready_i.
  - `ready_o` = !v1 || r2 (combinational).
  - `valid_o` = v2.
- Stage 1 loads on input transfer. v1 clears when stage 1 advances and there is no new input.
- Stage 2 loads when v1 && r2. v2 clears on output transfer when stage 1 has no beat to hand over.
- Simultaneous input transfer, stage advance and output transfer in one cycle keep full throughput.
- While valid_o && !ready_i, `sum_o`/`diff_o` hold stable.
- Out-of-range operands or even q: result undefined. No checking is done, except a simulation-only assertion.

## Timing
- Latency: 2 cycles from input transfer to `valid_o`, with an unstalled pipeline.
- Throughput: 1 beat/cycle.
- Capacity: 2 beats.
  - With ready_i held low, exactly 2 beats are accepted, then `ready_o` = 0.
  - After ready_i rises, `ready_o` returns high in the same cycle (combinational path).
- Reset:
  - v1 = v2 = 0; `valid_o` = 0; `ready_o` = 1 in the first cycle after reset.
  - All data registers = 0, so `sum_o` = `diff_o` = 0.
  - Reset mid-operation silently drops in-flight beats.
- Critical path: the W+1-bit add/compare/subtract in stage 1 and the W-bit add in stage 2, each within one cycle.

## Structure
- The shared VXU package holds:
  - `vxu_word_t`, a W-bit logic vector.
  - A `vxu_addsub_beat_t` struct (s, d, q, halve) for the stage-1 register.
- Sub-module: two instances of the existing `halfred` in stage 2, one for s and one for d. Their output is muxed with the unhalved value by halve.
- Stage-1 reduction is inline. No other sub-modules.

## Test plan
- **Basic, halved:** q=17, a=5, b=3, halve=1 → sum_o=4, diff_o=1, valid_o 2 cycles after accept.
- **Wrap and odd halving:** q=17, a=3, b=5, halve=1 → sum_o=4, diff_o=16 (d=15 odd → 7+9). Also a=b=16 → sum_o=16 (s=15 → 7+9), diff_o=0.
- **No halving:** q=17, a=10, b=9, halve=0 → sum_o=2, diff_o=1. Interleave with halve=1 beats and a q=97 beat back-to-back; each result uses its own q and halve.
- **Back-pressure:** stream 6 beats with ready_i=0 for 4 cycles.
  - Exactly 2 accepted, `ready_o`=0, `sum_o` stable while stalled.
  - On release, all 6 beats emerge in order with no loss or duplication.
  - Random valid_i/ready_i for 10k beats, checked against a reference model.
- **Wide modulus:** W=64, q=2^63−25, a=b=q−1, halve=1.
  - s=q−2 (odd) → sum_o=q−1.
  - diff_o=0.
  - The W+1-bit carry is exercised.
- **Reset mid-operation:** 2 beats in flight, assert rst_i for 1 cycle → `valid_o`=0, outputs 0, `ready_o`=1 next cycle. No stale beat appears afterwards.
